ascon_serial_shell: RTL and testbench
=====================================

// Module: ascon_serial_shell
// PURPOSE
//  Parametrised serial I/O shell for the masked, fault-protected Ascon encryption core.
//  - Deserialises D-share key/nonce/AD/PT and fault/mask randomness with a valid/ready handshake.
//  - Arms and starts the core, captures ciphertext and tag.
//  - Streams ciphertext and tag out W bits per beat with valid/ready/last.
// PARAMETERS
//  K   128  key length, bits (nonce and tag fixed at 128)
//  L   32   associated-data length, bits
//  Y   32   plaintext/ciphertext length, bits
//  D   3    number of shares per secret field (>=1)
//  W   1    bits per share lane per beat; K, L, Y, 64 and 128 must each divide by W
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous reset, active-high
//  key_i        in   D*W    key share lanes; lane s = bits [s*W +: W]
//  nonce_i      in   D*W    nonce share lanes
//  ad_i         in   D*W    AD share lanes
//  pt_i         in   D*W    PT share lanes
//  r64_i        in   7*W    seven 64-bit masking-randomness lanes
//  r128_i       in   W      128-bit fault-randomness lane
//  rpt_i        in   W      Y-bit fault-randomness lane
//  in_valid_i   in   1      input beat valid
//  in_ready_o   out  1      input beat accepted when valid&ready
//  start_i      in   1      encryption request
//  busy_o       out  1      high outside IDLE
//  key_sh_o     out  D*K    share s at [s*K +: K]
//  nonce_sh_o   out  D*128  nonce shares to core
//  ad_sh_o      out  D*L    AD shares to core
//  pt_sh_o      out  D*Y    PT shares to core
//  r64_o        out  7*64   masking randomness to core
//  r128_o       out  128    fault randomness to core
//  rpt_o        out  Y      fault randomness to core
//  core_start_o out  1      one-cycle start pulse to core
//  core_done_i  in   1      core result valid (level or pulse)
//  core_ct_i    in   Y      core ciphertext
//  core_tag_i   in   128    core tag
//  ct_o         out  W      ciphertext beat
//  tag_o        out  W      tag beat
//  out_valid_o  out  1      output beat valid
//  out_ready_i  in   1      output beat consumed when valid&ready
//  out_last_o   out  1      final output beat
//  done_o       out  1      one-cycle pulse after last output handshake
// BEHAVIOUR
//  Reset:
//  - State=IDLE; all share, randomness and result registers cleared.
//  - Counters cleared; every output 0.
//  FSM:
//  - IDLE: in_ready_o=1; the first accepted beat is loaded and moves to LOAD.
//  - LOAD: in_ready_o=1; each accepted beat shifts all active fields.
//    - Fields are shifted MSB first: reg <= {reg[N-W-1:0], lane}.
//    - A field of N bits takes only beats 0..N/W-1 and ignores later lanes.
//    - NB = max(K,128,L,Y,64)/W beats total; after beat NB-1 is accepted -> ARMED.
//  - ARMED: in_ready_o=0; start_i=1 -> core_start_o=1 for exactly one cycle -> RUN.
//  - RUN: core_done_i=1 captures core_ct_i/core_tag_i into the output shift registers -> UNLOAD.
//  - UNLOAD: out_valid_o=1; TB = 128/W beats, output LSB first.
//    - Beat n: tag_o = tag[n*W +: W].
//    - ct_o = ct[n*W +: W] for n < Y/W, else 0 (if Y > 128, the remaining ct bits are not output).
//    - Beat index advances only on valid&ready; out_valid_o holds until accepted.
//    - out_last_o = out_valid_o on beat TB-1.
//    - After the last handshake: done_o=1 for the next cycle, state -> IDLE.
//  Register visibility and hold:
//  - Shares and randomness are visible on the core outputs from LOAD onward.
//  - They hold unchanged through ARMED, RUN and UNLOAD and are cleared only by rst.
//  - A new LOAD overwrites them.
//  Boundary conditions:
//  - Beat counter width $clog2(max(NB,TB)+1); it never wraps and saturates at the terminal beat.
//  - start_i is ignored outside ARMED; core_done_i is ignored outside RUN.
//  - in_valid_i with in_ready_o=0 does not change state or registers.
//  - start_i and core_done_i in the same cycle: only start is acted on.
//  - rst mid-LOAD, RUN or UNLOAD: immediate return to IDLE, all cleared, no done_o.
// TESTING
//  1 Load/start (D=3,W=1):
//    - Stimulus: share0 key=0x000102..0F, shares1/2=0; 128 beats; start.
//    - Response: key_sh_o[127:0]=0x000102..0F; ARMED at beat 128; single core_start_o pulse.
//  2 Unload:
//    - Stimulus: core_done_i with ct=0xDEADBEEF, tag=0x0123..CDEF.
//    - Response: 128 beats; ct_o bits 0..31 = 0xDEADBEEF LSB first, then 0.
//    - out_last_o on beat 127; done_o on the next cycle.
//  3 Backpressure:
//    - Stimulus: toggle out_ready_i low every other cycle.
//    - Response: no lost or duplicated beats; beats hold while out_ready_i=0.
//  4 W=8, D=2:
//    - Stimulus: 16 load beats.
//    - Response: AD complete after 4 beats, PT after 4, r64 after 8; tag streams in 16 beats.
//  5 Illegal timing:
//    - Stimulus: start_i during LOAD; core_done_i during ARMED.
//    - Response: no state change; in_valid_i gaps stall the load without loss.
//  6 Reset mid-UNLOAD:
//    - Stimulus: rst at beat 50.
//    - Response: next cycle IDLE, all outputs 0, done_o never pulses.
//    - A fresh load then completes normally.

Source files
------------

// File: rtl/ascon_serial_shell.sv
// Serial I/O shell for the masked Ascon core: deserialises shares and randomness,
// arms and starts the core, then streams ciphertext and tag back out W bits per beat.

module ascon_shift_field #(
    parameter int N  = 128,
    parameter int W  = 1,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [CW-1:0] beat,
    input  logic [W-1:0]  lane,
    output logic [N-1:0]  q
);
    localparam int NBEATS = N / W;

    logic [N+W-1:0] cat;
    logic [N-1:0]   q_reg;

    // MSB-first shift; the field stops listening once its own N/W beats are in
    assign cat = {q_reg, lane};
    assign q   = q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (load_en && (beat < CW'(NBEATS))) begin
            q_reg <= cat[N-1:0];
        end
    end
endmodule

module ascon_serial_shell #(
    parameter int K = 128,
    parameter int L = 32,
    parameter int Y = 32,
    parameter int D = 3,
    parameter int W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [D*W-1:0]   key_i,
    input  logic [D*W-1:0]   nonce_i,
    input  logic [D*W-1:0]   ad_i,
    input  logic [D*W-1:0]   pt_i,
    input  logic [7*W-1:0]   r64_i,
    input  logic [W-1:0]     r128_i,
    input  logic [W-1:0]     rpt_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             start_i,
    output logic             busy_o,
    output logic [D*K-1:0]   key_sh_o,
    output logic [D*128-1:0] nonce_sh_o,
    output logic [D*L-1:0]   ad_sh_o,
    output logic [D*Y-1:0]   pt_sh_o,
    output logic [7*64-1:0]  r64_o,
    output logic [127:0]     r128_o,
    output logic [Y-1:0]     rpt_o,
    output logic             core_start_o,
    input  logic             core_done_i,
    input  logic [Y-1:0]     core_ct_i,
    input  logic [127:0]     core_tag_i,
    output logic [W-1:0]     ct_o,
    output logic [W-1:0]     tag_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             done_o
);
    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int NB = max_i(max_i(max_i(K, 128), max_i(L, Y)), 64) / W;
    localparam int TB = 128 / W;
    localparam int CW = $clog2(max_i(NB, TB) + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, RUN, UNLOAD} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          start_reg, start_next;
    logic          done_reg, done_next;
    logic [127:0]  tag_sh_reg;
    logic [Y-1:0]  ct_sh_reg;
    logic          load_en, out_fire, capture;

    assign in_ready_o   = (state_reg == IDLE) || (state_reg == LOAD);
    assign load_en      = in_valid_i && in_ready_o;
    assign busy_o       = (state_reg != IDLE);
    assign out_valid_o  = (state_reg == UNLOAD);
    assign out_fire     = out_valid_o && out_ready_i;
    assign out_last_o   = out_valid_o && (cnt_reg == CW'(TB - 1));
    assign capture      = (state_reg == RUN) && core_done_i;
    assign tag_o        = out_valid_o ? tag_sh_reg[W-1:0] : '0;
    assign ct_o         = out_valid_o ? ct_sh_reg[W-1:0] : '0;
    assign core_start_o = start_reg;
    assign done_o       = done_reg;

    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_share
            ascon_shift_field #(.N(K), .W(W), .CW(CW)) u_key (
                .clk(clk), .rst(rst), .load_en(load_en), .beat(cnt_reg),
                .lane(key_i[gi*W +: W]), .q(key_sh_o[gi*K +: K]));
            ascon_shift_field #(.N(128), .W(W), .CW(CW)) u_nonce (
                .clk(clk), .rst(rst), .load_en(load_en), .beat(cnt_reg),
                .lane(nonce_i[gi*W +: W]), .q(nonce_sh_o[gi*128 +: 128]));
            ascon_shift_field #(.N(L), .W(W), .CW(CW)) u_ad (
                .clk(clk), .rst(rst), .load_en(load_en), .beat(cnt_reg),
                .lane(ad_i[gi*W +: W]), .q(ad_sh_o[gi*L +: L]));
            ascon_shift_field #(.N(Y), .W(W), .CW(CW)) u_pt (
                .clk(clk), .rst(rst), .load_en(load_en), .beat(cnt_reg),
                .lane(pt_i[gi*W +: W]), .q(pt_sh_o[gi*Y +: Y]));
        end
        for (gi = 0; gi < 7; gi++) begin : g_r64
            ascon_shift_field #(.N(64), .W(W), .CW(CW)) u_r64 (
                .clk(clk), .rst(rst), .load_en(load_en), .beat(cnt_reg),
                .lane(r64_i[gi*W +: W]), .q(r64_o[gi*64 +: 64]));
        end
    endgenerate

    ascon_shift_field #(.N(128), .W(W), .CW(CW)) u_r128 (
        .clk(clk), .rst(rst), .load_en(load_en), .beat(cnt_reg),
        .lane(r128_i), .q(r128_o));
    ascon_shift_field #(.N(Y), .W(W), .CW(CW)) u_rpt (
        .clk(clk), .rst(rst), .load_en(load_en), .beat(cnt_reg),
        .lane(rpt_i), .q(rpt_o));

    // Results shift out LSB first; ct zero-fills so beats past Y/W read as 0
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_sh_reg <= '0;
            ct_sh_reg  <= '0;
        end else if (capture) begin
            tag_sh_reg <= core_tag_i;
            ct_sh_reg  <= core_ct_i;
        end else if (out_fire) begin
            tag_sh_reg <= tag_sh_reg >> W;
            ct_sh_reg  <= ct_sh_reg >> W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            start_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            start_reg <= start_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        start_next = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE, LOAD: begin
                if (load_en) begin
                    if (cnt_reg == CW'(NB - 1)) begin
                        state_next = ARMED;
                        cnt_next   = '0;
                    end else begin
                        state_next = LOAD;
                        cnt_next   = cnt_reg + CW'(1);
                    end
                end
            end
            ARMED: begin
                if (start_i) begin
                    state_next = RUN;
                    start_next = 1'b1;
                end
            end
            RUN: begin
                if (core_done_i) begin
                    state_next = UNLOAD;
                end
            end
            UNLOAD: begin
                if (out_ready_i) begin
                    if (cnt_reg == CW'(TB - 1)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ascon_serial_shell.sv
`define CHK(t, o, e) chk(t, 512'(o), 512'(e))

module tb_ascon_serial_shell;
    localparam int K = 128, L = 32, Y = 32, D = 3, W = 1;
    localparam int NB = 128, TB = 128;
    localparam int BW = 8, BD = 2, BNB = 16, BTB = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [D*W-1:0] key_i, nonce_i, ad_i, pt_i;
    logic [7*W-1:0] r64_i;
    logic [W-1:0] r128_i, rpt_i, ct_o, tag_o;
    logic in_valid_i, in_ready_o, start_i, busy_o, core_start_o, core_done_i;
    logic out_valid_o, out_ready_i, out_last_o, done_o;
    logic [D*K-1:0] key_sh_o;
    logic [D*128-1:0] nonce_sh_o;
    logic [D*L-1:0] ad_sh_o;
    logic [D*Y-1:0] pt_sh_o;
    logic [447:0] r64_o;
    logic [127:0] r128_o, core_tag_i;
    logic [Y-1:0] rpt_o, core_ct_i;

    logic [BD*BW-1:0] b_key_i, b_nonce_i, b_ad_i, b_pt_i;
    logic [7*BW-1:0] b_r64_i;
    logic [BW-1:0] b_r128_i, b_rpt_i, b_ct_o, b_tag_o;
    logic b_in_valid_i, b_in_ready_o, b_start_i, b_busy_o, b_core_start_o, b_core_done_i;
    logic b_out_valid_o, b_out_ready_i, b_out_last_o, b_done_o;
    logic [BD*K-1:0] b_key_sh_o;
    logic [BD*128-1:0] b_nonce_sh_o;
    logic [BD*L-1:0] b_ad_sh_o;
    logic [BD*Y-1:0] b_pt_sh_o;
    logic [447:0] b_r64_o;
    logic [127:0] b_r128_o, b_core_tag_i;
    logic [Y-1:0] b_rpt_o, b_core_ct_i;

    ascon_serial_shell #(.K(K), .L(L), .Y(Y), .D(D), .W(W)) dut_a (
        .clk(clk), .rst(rst), .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i), .pt_i(pt_i),
        .r64_i(r64_i), .r128_i(r128_i), .rpt_i(rpt_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .start_i(start_i), .busy_o(busy_o), .key_sh_o(key_sh_o),
        .nonce_sh_o(nonce_sh_o), .ad_sh_o(ad_sh_o), .pt_sh_o(pt_sh_o), .r64_o(r64_o),
        .r128_o(r128_o), .rpt_o(rpt_o), .core_start_o(core_start_o), .core_done_i(core_done_i),
        .core_ct_i(core_ct_i), .core_tag_i(core_tag_i), .ct_o(ct_o), .tag_o(tag_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_last_o(out_last_o),
        .done_o(done_o));

    ascon_serial_shell #(.K(K), .L(L), .Y(Y), .D(BD), .W(BW)) dut_b (
        .clk(clk), .rst(rst), .key_i(b_key_i), .nonce_i(b_nonce_i), .ad_i(b_ad_i),
        .pt_i(b_pt_i), .r64_i(b_r64_i), .r128_i(b_r128_i), .rpt_i(b_rpt_i),
        .in_valid_i(b_in_valid_i), .in_ready_o(b_in_ready_o), .start_i(b_start_i),
        .busy_o(b_busy_o), .key_sh_o(b_key_sh_o), .nonce_sh_o(b_nonce_sh_o),
        .ad_sh_o(b_ad_sh_o), .pt_sh_o(b_pt_sh_o), .r64_o(b_r64_o), .r128_o(b_r128_o),
        .rpt_o(b_rpt_o), .core_start_o(b_core_start_o), .core_done_i(b_core_done_i),
        .core_ct_i(b_core_ct_i), .core_tag_i(b_core_tag_i), .ct_o(b_ct_o), .tag_o(b_tag_o),
        .out_valid_o(b_out_valid_o), .out_ready_i(b_out_ready_i), .out_last_o(b_out_last_o),
        .done_o(b_done_o));

    int passed = 0, failed = 0, total = 0;
    int done_seen = 0, b_done_seen = 0;
    logic [127:0] key0 = 128'h000102030405060708090A0B0C0D0E0F;
    logic [127:0] tag0 = 128'h0123456789ABCDEF0123456789ABCDEF;

    logic [D*W-1:0] sk [NB], sn [NB], sa [NB], sp [NB];
    logic [7*W-1:0] sr64 [NB];
    logic [W-1:0] sr128 [NB], srpt [NB];
    logic [D*K-1:0] ek;
    logic [D*128-1:0] en;
    logic [D*L-1:0] ea;
    logic [D*Y-1:0] ep;
    logic [447:0] er64;
    logic [127:0] er128;
    logic [Y-1:0] erpt;

    logic [BD*BW-1:0] bk [BNB], bn [BNB], ba [BNB], bpt [BNB];
    logic [7*BW-1:0] br64 [BNB];
    logic [BW-1:0] br128 [BNB], brpt [BNB];
    logic [BD*K-1:0] bek;
    logic [BD*128-1:0] ben;
    logic [BD*L-1:0] bea;
    logic [BD*Y-1:0] bep;
    logic [447:0] ber64;
    logic [127:0] ber128;
    logic [Y-1:0] berpt;

    always @(negedge clk) begin
        if (done_o) done_seen <= done_seen + 1;
        if (b_done_o) b_done_seen <= b_done_seen + 1;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_a(input bit fixed_key);
        logic [31:0] r;
        for (int b = 0; b < NB; b++) begin
            r = $urandom;
            sk[b] = r[2:0]; sn[b] = r[5:3]; sa[b] = r[8:6]; sp[b] = r[11:9];
            sr64[b] = r[18:12]; sr128[b] = r[19]; srpt[b] = r[20];
            if (fixed_key) sk[b] = {2'b00, key0[127-b]};
        end
    endtask

    task automatic model_a();
        for (int s = 0; s < D; s++) begin
            for (int b = 0; b < K/W; b++)   ek[s*K + (K/W-1-b)*W +: W] = sk[b][s*W +: W];
            for (int b = 0; b < 128/W; b++) en[s*128 + (128/W-1-b)*W +: W] = sn[b][s*W +: W];
            for (int b = 0; b < L/W; b++)   ea[s*L + (L/W-1-b)*W +: W] = sa[b][s*W +: W];
            for (int b = 0; b < Y/W; b++)   ep[s*Y + (Y/W-1-b)*W +: W] = sp[b][s*W +: W];
        end
        for (int j = 0; j < 7; j++)
            for (int b = 0; b < 64/W; b++) er64[j*64 + (64/W-1-b)*W +: W] = sr64[b][j*W +: W];
        for (int b = 0; b < 128/W; b++) er128[(128/W-1-b)*W +: W] = sr128[b];
        for (int b = 0; b < Y/W; b++)   erpt[(Y/W-1-b)*W +: W] = srpt[b];
    endtask

    task automatic load_a();
        int b = 0;
        int cyc = 0;
        logic [31:0] r;
        logic v;
        while (b < NB && cyc < 4*NB) begin
            r = $urandom;
            v = (r[2:0] != 3'd0);
            in_valid_i = v;
            start_i = r[3] & r[4];
            key_i = v ? sk[b] : ~sk[b];   nonce_i = v ? sn[b] : ~sn[b];
            ad_i = v ? sa[b] : ~sa[b];    pt_i = v ? sp[b] : ~sp[b];
            r64_i = v ? sr64[b] : ~sr64[b];
            r128_i = v ? sr128[b] : ~sr128[b];
            rpt_i = v ? srpt[b] : ~srpt[b];
            tick();
            cyc++;
            if (v) begin
                b++;
                if (b == L/W) begin
                    total++;
                    if (ad_sh_o !== ea) begin
                        failed++;
                        $error("FAIL ad_complete_mid observed=%0h expected=%0h", ad_sh_o, ea);
                    end else begin
                        passed++;
                    end
                    `CHK("pt_complete_mid", pt_sh_o, ep);
                    `CHK("in_load", {busy_o, in_ready_o}, 2'b11);
                end
            end
        end
        in_valid_i = 1'b0;
        start_i = 1'b0;
        `CHK("load_beats", b, NB);
    endtask

    task automatic check_fields_a();
        `CHK("armed_state", {busy_o, in_ready_o, out_valid_o}, 3'b100);
        `CHK("key_sh", key_sh_o, ek);
        `CHK("nonce_sh", nonce_sh_o, en);
        `CHK("ad_sh", ad_sh_o, ea);
        `CHK("pt_sh", pt_sh_o, ep);
        `CHK("r64", r64_o, er64);
        `CHK("r128", r128_o, er128);
        `CHK("rpt", rpt_o, erpt);
    endtask

    task automatic armed_a();
        int pulses = 0;
        in_valid_i = 1'b1;
        key_i = ~sk[0]; ad_i = ~sa[0]; r64_i = ~sr64[0];
        core_done_i = 1'b1;
        repeat (3) tick();
        `CHK("armed_hold", {busy_o, in_ready_o, out_valid_o, core_start_o}, 4'b1000);
        `CHK("armed_key_hold", key_sh_o, ek);
        `CHK("armed_r64_hold", r64_o, er64);
        in_valid_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        core_done_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (core_start_o) pulses++;
            if (i < 4) tick();
        end
        `CHK("start_pulses", pulses, 1);
        `CHK("run_no_capture", {busy_o, out_valid_o}, 2'b10);
    endtask

    task automatic result_a(input logic [Y-1:0] ct, input logic [127:0] tag);
        core_ct_i = ct;
        core_tag_i = tag;
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        core_ct_i = ~ct;
        core_tag_i = ~tag;
        `CHK("capture_valid", out_valid_o, 1'b1);
    endtask

    task automatic unload_a(input bit bp, input int stop_at, input logic [Y-1:0] ct,
                            input logic [127:0] tag);
        int idx = 0;
        int cyc = 0;
        logic phase = 1'b0;
        logic [W-1:0] ect;
        logic [2*W+1:0] obs_v, exp_v;
        while (idx < stop_at && cyc < 1000) begin
            out_ready_i = bp ? phase : 1'b1;
            phase = ~phase;
            ect = '0;
            if (idx < Y/W) ect = ct[idx*W +: W];
            obs_v = {out_valid_o, out_last_o, ct_o, tag_o};
            exp_v = {1'b1, (idx == TB-1), ect, tag[idx*W +: W]};
            total++;
            if (obs_v !== exp_v) begin
                failed++;
                $error("FAIL unload_beat %0d observed=%0h expected=%0h", idx, obs_v, exp_v);
            end else begin
                passed++;
            end
            tick();
            cyc++;
            if (out_ready_i) idx++;
        end
        out_ready_i = 1'b0;
        `CHK("unload_beats", idx, stop_at);
        if (stop_at == TB) begin
            `CHK("done_pulse", {done_o, busy_o, out_valid_o}, 3'b100);
            tick();
            `CHK("done_clear", done_o, 1'b0);
        end
    endtask

    task automatic run_a(input bit fixed_key, input bit bp, input int stop_at,
                         input logic [Y-1:0] ct, input logic [127:0] tag);
        gen_a(fixed_key);
        model_a();
        load_a();
        check_fields_a();
        armed_a();
        result_a(ct, tag);
        unload_a(bp, stop_at, ct, tag);
    endtask

    task automatic run_b();
        logic [31:0] r, r2;
        logic [Y-1:0] ct;
        logic [127:0] tag;
        int idx = 0;
        int cyc = 0;
        logic [BW-1:0] ect;
        logic [2*BW+1:0] obs_v, exp_v;
        for (int b = 0; b < BNB; b++) begin
            r = $urandom; r2 = $urandom;
            bk[b] = r[15:0]; bn[b] = r[31:16]; ba[b] = r2[15:0]; bpt[b] = r2[31:16];
            r = $urandom; r2 = $urandom;
            br64[b] = {r[23:0], r2}; br128[b] = r[31:24];
            r = $urandom;
            brpt[b] = r[7:0];
        end
        for (int s = 0; s < BD; s++) begin
            for (int b = 0; b < K/BW; b++)   bek[s*K + (K/BW-1-b)*BW +: BW] = bk[b][s*BW +: BW];
            for (int b = 0; b < 128/BW; b++) ben[s*128 + (128/BW-1-b)*BW +: BW] = bn[b][s*BW +: BW];
            for (int b = 0; b < L/BW; b++)   bea[s*L + (L/BW-1-b)*BW +: BW] = ba[b][s*BW +: BW];
            for (int b = 0; b < Y/BW; b++)   bep[s*Y + (Y/BW-1-b)*BW +: BW] = bpt[b][s*BW +: BW];
        end
        for (int j = 0; j < 7; j++)
            for (int b = 0; b < 64/BW; b++) ber64[j*64 + (64/BW-1-b)*BW +: BW] = br64[b][j*BW +: BW];
        for (int b = 0; b < 128/BW; b++) ber128[(128/BW-1-b)*BW +: BW] = br128[b];
        for (int b = 0; b < Y/BW; b++)   berpt[(Y/BW-1-b)*BW +: BW] = brpt[b];

        for (int b = 0; b < BNB; b++) begin
            b_in_valid_i = 1'b1;
            b_key_i = bk[b]; b_nonce_i = bn[b]; b_ad_i = ba[b]; b_pt_i = bpt[b];
            b_r64_i = br64[b]; b_r128_i = br128[b]; b_rpt_i = brpt[b];
            tick();
            if (b == 3) begin
                `CHK("b_ad_after4", b_ad_sh_o, bea);
                `CHK("b_pt_after4", b_pt_sh_o, bep);
            end
            if (b == 7) `CHK("b_r64_after8", b_r64_o, ber64);
        end
        b_in_valid_i = 1'b0;
        `CHK("b_armed", {b_busy_o, b_in_ready_o}, 2'b10);
        `CHK("b_key", b_key_sh_o, bek);
        `CHK("b_nonce", b_nonce_sh_o, ben);
        `CHK("b_ad_final", b_ad_sh_o, bea);
        `CHK("b_pt_final", b_pt_sh_o, bep);
        `CHK("b_r64_final", b_r64_o, ber64);
        `CHK("b_r128", b_r128_o, ber128);
        `CHK("b_rpt", b_rpt_o, berpt);

        b_start_i = 1'b1;
        tick();
        b_start_i = 1'b0;
        `CHK("b_start", b_core_start_o, 1'b1);
        ct = $urandom;
        tag = {$urandom, $urandom, $urandom, $urandom};
        b_core_ct_i = ct; b_core_tag_i = tag; b_core_done_i = 1'b1;
        tick();
        b_core_done_i = 1'b0;
        while (idx < BTB && cyc < 200) begin
            r = $urandom;
            b_out_ready_i = r[0];
            ect = '0;
            if (idx < Y/BW) ect = ct[idx*BW +: BW];
            obs_v = {b_out_valid_o, b_out_last_o, b_ct_o, b_tag_o};
            exp_v = {1'b1, (idx == BTB-1), ect, tag[idx*BW +: BW]};
            total++;
            if (obs_v !== exp_v) begin
                failed++;
                $error("FAIL b_unload_beat %0d observed=%0h expected=%0h", idx, obs_v, exp_v);
            end else begin
                passed++;
            end
            tick();
            cyc++;
            if (b_out_ready_i) idx++;
        end
        b_out_ready_i = 1'b0;
        `CHK("b_unload_beats", idx, BTB);
        `CHK("b_done", {b_done_o, b_busy_o}, 2'b10);
        $display("txB: W=8 D=2 load of %0d beats, unload of %0d beats", BNB, idx);
    endtask

    initial begin
        logic [Y-1:0] rct;
        logic [127:0] rtag;
        int seen;
        rst = 1'b1;
        key_i = '0; nonce_i = '0; ad_i = '0; pt_i = '0; r64_i = '0; r128_i = '0; rpt_i = '0;
        in_valid_i = 1'b0; start_i = 1'b0; core_done_i = 1'b0; core_ct_i = '0; core_tag_i = '0;
        out_ready_i = 1'b0;
        b_key_i = '0; b_nonce_i = '0; b_ad_i = '0; b_pt_i = '0; b_r64_i = '0; b_r128_i = '0;
        b_rpt_i = '0; b_in_valid_i = 1'b0; b_start_i = 1'b0; b_core_done_i = 1'b0;
        b_core_ct_i = '0; b_core_tag_i = '0; b_out_ready_i = 1'b0;
        repeat (3) tick();
        `CHK("reset_ctrl", {busy_o, out_valid_o, out_last_o, core_start_o, done_o}, 5'b0);
        `CHK("reset_key", key_sh_o, 0);
        `CHK("reset_r64", r64_o, 0);
        `CHK("reset_outs", {ct_o, tag_o, r128_o, rpt_o}, 0);
        rst = 1'b0;
        tick();

        run_a(1'b1, 1'b1, TB, 32'hDEADBEEF, tag0);
        `CHK("key_share0_const", key_sh_o[127:0], key0);
        `CHK("key_share12_zero", key_sh_o[3*K-1:K], 0);
        $display("tx1: fixed key loaded, ct/tag streamed with backpressure");

        rct = $urandom;
        rtag = {$urandom, $urandom, $urandom, $urandom};
        run_a(1'b0, 1'b0, 50, rct, rtag);
        seen = done_seen;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        `CHK("rst_ctrl", {busy_o, out_valid_o, out_last_o, core_start_o, done_o}, 5'b0);
        `CHK("rst_key", key_sh_o, 0);
        `CHK("rst_nonce", nonce_sh_o, 0);
        `CHK("rst_r64", r64_o, 0);
        `CHK("rst_outs", {ct_o, tag_o, r128_o, rpt_o}, 0);
        repeat (10) tick();
        `CHK("rst_no_done", done_seen, seen);
        $display("tx2: reset during unload at beat 50");

        rct = $urandom;
        rtag = {$urandom, $urandom, $urandom, $urandom};
        run_a(1'b0, 1'b1, TB, rct, rtag);
        $display("tx3: fresh load after reset, full unload");

        run_b();
        tick();
        `CHK("done_count_a", done_seen, 2);
        `CHK("done_count_b", b_done_seen, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
